// File: rtl/updown_count_jk.sv
// Purpose : parametrised modulo-MODULUS up/down counter built from JK stages, with load, tc and wrap flags.
// Latency : count/wrap/load_err update one clock after inputs are sampled; tc is combinational.
// Backpressure: none; en=0 holds the count, load overrides en.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (count=0, wrap=0, load_err=0)
//   en       count enable
//   up       direction, 1 = increment, 0 = decrement
//   load     synchronous parallel load, overrides en
//   din      load value; values >= MODULUS saturate to MODULUS-1 and flag load_err
//   count    registered counter value
//   tc       terminal count: next enabled edge will wrap (for cascading)
//   wrap     one-cycle pulse coinciding with the wrapped count value
//   load_err one-cycle pulse coinciding with a saturated load
module updown_count_jk #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    // Illegal parameter sets stop elaboration.
    if (WIDTH < 2 || WIDTH > 16) begin : g_width_err
        $error("updown_count_jk: WIDTH must be in 2..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_mod_err
        $error("updown_count_jk: MODULUS must be in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             wrap_nxt;
    logic             err_nxt;

    // Arithmetic next-state; priority load > en > hold.
    always_comb begin
        nxt      = count;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (load) begin
            if (din > MAX) begin
                nxt     = MAX;
                err_nxt = 1'b1;
            end else begin
                nxt = din;
            end
        end else if (en) begin
            if (up) begin
                if (count == MAX) begin
                    nxt      = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    nxt      = MAX;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = count - 1'b1;
                end
            end
        end
    end

    // JK excitation: set bits going 0->1, reset bits going 1->0, leave the rest alone.
    assign j = nxt & ~count;
    assign k = ~nxt & count;

    // Characteristic equation Q+ = J~Q | ~KQ applied per bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= (j & ~count) | (~k & count);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= wrap_nxt;
            load_err <= err_nxt;
        end
    end

    assign tc = en & ~load & ((up & (count == MAX)) | (~up & (count == '0)));

endmodule

// File: tb/tb_updown_count_jk.sv
module tb_updown_count_jk;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up  = 1'b1;
    logic [2:0] din = 3'd0;
    logic [3:0] din4;
    logic       en8 = 1'b0, load8 = 1'b0;
    logic       en6 = 1'b0, load6 = 1'b0;
    logic       en16 = 1'b0, load16 = 1'b0;

    logic [2:0] count8, count6;
    logic [3:0] count16;
    logic       tc8, wrap8, err8;
    logic       tc6, wrap6, err6;
    logic       tc16, wrap16, err16;

    int checks   = 0;
    int failures = 0;
    int m;

    assign din4 = {1'b0, din};

    always #5 clk = ~clk;

    updown_count_jk #(.WIDTH(3), .MODULUS(8)) u8 (
        .clk(clk), .rst(rst), .en(en8), .up(up), .load(load8), .din(din),
        .count(count8), .tc(tc8), .wrap(wrap8), .load_err(err8));

    updown_count_jk #(.WIDTH(3), .MODULUS(6)) u6 (
        .clk(clk), .rst(rst), .en(en6), .up(up), .load(load6), .din(din),
        .count(count6), .tc(tc6), .wrap(wrap6), .load_err(err6));

    updown_count_jk #(.WIDTH(4), .MODULUS(16)) u16 (
        .clk(clk), .rst(rst), .en(en16), .up(up), .load(load16), .din(din4),
        .count(count16), .tc(tc16), .wrap(wrap16), .load_err(err16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, asynchronous (no edge yet).
        #1;
        check("rst_count8", count8, 0);
        check("rst_wrap8", wrap8, 0);
        check("rst_err8", err8, 0);
        check("rst_count6", count6, 0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset mid-count on u8.
        load8 = 1'b1; din = 3'd5;
        step();
        check("ld5_count8", count8, 5);
        load8 = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_count8", count8, 0);
        check("arst_wrap8", wrap8, 0);
        #1 rst = 1'b0;
        en8 = 1'b1; up = 1'b1;
        step(); check("post_rst1", count8, 1);
        step(); check("post_rst2", count8, 2);
        step(); check("post_rst3", count8, 3);
        en8 = 1'b0;

        // Modulo-6 up wrap from 0.
        en6 = 1'b1; up = 1'b1;
        check("up_tc_at0", tc6, 0);
        for (int i = 1; i <= 6; i++) begin
            step();
            check("up6_count", count6, i % 6);
            check("up6_wrap", wrap6, (i == 6) ? 1 : 0);
            check("up6_tc", tc6, ((i % 6) == 5) ? 1 : 0);
        end

        // Modulo-6 down wrap from 2; load also clears the previous wrap.
        load6 = 1'b1; din = 3'd2;
        step();
        check("dn_ld_count", count6, 2);
        check("dn_ld_wrap", wrap6, 0);
        check("dn_ld_err", err6, 0);
        load6 = 1'b0; up = 1'b0;
        check("dn_tc_at2", tc6, 0);
        step(); check("dn_c1", count6, 1); check("dn_tc1", tc6, 0); check("dn_w1", wrap6, 0);
        step(); check("dn_c0", count6, 0); check("dn_tc0", tc6, 1); check("dn_w0", wrap6, 0);
        step(); check("dn_c5", count6, 5); check("dn_tc5", tc6, 0); check("dn_w5", wrap6, 1);
        step(); check("dn_c4", count6, 4); check("dn_w4", wrap6, 0);

        // Load priority over en, and out-of-range saturation.
        load6 = 1'b1; din = 3'd3;
        check("ld_tc_masked", tc6, 0);
        step();
        check("ld3_count", count6, 3);
        check("ld3_err", err6, 0);
        din = 3'd7;
        step();
        check("ld7_count", count6, 5);
        check("ld7_err", err6, 1);
        check("ld7_wrap", wrap6, 0);
        load6 = 1'b0; en6 = 1'b0;
        step();
        check("ld7_hold_count", count6, 5);
        check("ld7_err_clear", err6, 0);

        // Hold at 4, then direction flip every edge.
        load6 = 1'b1; din = 3'd4;
        step();
        load6 = 1'b0; en6 = 1'b0; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_count", count6, 4);
            check("hold_tc", tc6, 0);
        end
        en6 = 1'b1; up = 1'b1;
        step(); check("flip_c5a", count6, 5);
        check("flip_tc_up", tc6, 1);
        en6 = 1'b0; #1;
        check("flip_tc_en0", tc6, 0);
        en6 = 1'b1; up = 1'b0; #1;
        check("flip_tc_dn", tc6, 0);
        step(); check("flip_c4a", count6, 4);
        up = 1'b1;
        step(); check("flip_c5b", count6, 5); check("flip_nowrap", wrap6, 0);
        up = 1'b0;
        step(); check("flip_c4b", count6, 4);
        en6 = 1'b0;

        // Full binary range on the 4-bit, modulus-16 instance.
        up = 1'b1; en16 = 1'b1;
        m = 0;
        check("full_start", count16, 0);
        for (int c = 1; c <= 40; c++) begin
            step();
            m = (m + 1) % 16;
            check("full_count", count16, m);
            check("full_wrap", wrap16, (c == 16 || c == 32) ? 1 : 0);
        end
        en16 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
